// File: rtl/mmio_arbiter.sv
// Round-robin arbiter that lets several bus masters share the MMIO register bank.
// One single-word transaction per two cycles: accept in IDLE, respond in RESP.
module mmio_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int NUM_REGS = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ-1:0]           req_lock,
    input  logic [NUM_REQ-1:0][2:0]      req_addr,
    input  logic [NUM_REQ-1:0][31:0]     req_wdata,
    input  logic [NUM_REQ-1:0][3:0]      req_byteen,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [31:0]                  rsp_rdata,
    input  logic [NUM_REGS-1:0][31:0]    mmio_inputs,
    output logic [NUM_REGS-1:0][31:0]    mmio_outputs
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_t;

    function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? wd[8*k +: 8] : cur[8*k +: 8];
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        logic [IW:0] s;
        s = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
        return (s >= (IW+1)'(NUM_REQ)) ? {IW{1'b0}} : IW'(s);
    endfunction

    state_t                     state_r, state_nx_s;
    logic [IW-1:0]              rr_ptr_r;
    logic                       lock_valid_r;
    logic [IW-1:0]              lock_owner_r;
    logic [CW-1:0]              lock_count_r;
    logic [NUM_REQ-1:0]         rsp_valid_r;
    logic [31:0]                rsp_rdata_r;
    logic [NUM_REGS-1:0][31:0]  mmio_r;

    logic                       scan_hit_s;
    logic [IW-1:0]              scan_win_s;
    logic [IW:0]                sum_s;
    logic [IW-1:0]              cand_s;
    logic                       lock_hit_s;
    logic [IW-1:0]              win_s;
    logic                       grant_s;
    logic [NUM_REQ-1:0]         grant_vec_s;
    logic [CW-1:0]              cnt_eff_s;
    logic                       keep_lock_s;
    logic [2:0]                 addr_s;
    logic                       in_range_s;
    logic [RW-1:0]              reg_idx_s;
    logic [31:0]                cur_s;
    logic [31:0]                merged_s;

    // Round-robin scan upward from rr_ptr, wrapping at NUM_REQ
    always_comb begin
        scan_hit_s = 1'b0;
        scan_win_s = '0;
        sum_s      = '0;
        cand_s     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s  = {1'b0, rr_ptr_r} + (IW+1)'(i);
            cand_s = (sum_s >= (IW+1)'(NUM_REQ)) ? IW'(sum_s - (IW+1)'(NUM_REQ)) : IW'(sum_s);
            if (!scan_hit_s && req_valid[cand_s]) begin
                scan_hit_s = 1'b1;
                scan_win_s = cand_s;
            end else begin
                scan_hit_s = scan_hit_s;
            end
        end
    end

    // A still-valid lock owner overrides the rotation
    assign lock_hit_s  = lock_valid_r && req_valid[lock_owner_r];
    assign win_s       = lock_hit_s ? lock_owner_r : scan_win_s;
    assign grant_s     = reset && (state_r == ST_IDLE) && (lock_hit_s || scan_hit_s);
    assign cnt_eff_s   = lock_hit_s ? lock_count_r : {CW{1'b0}};
    assign keep_lock_s = req_lock[win_s] && ((int'(cnt_eff_s) + 1) < LOCK_MAX);

    assign addr_s     = req_addr[win_s];
    assign in_range_s = (32'(addr_s) < 32'(NUM_REGS));
    assign reg_idx_s  = addr_s[RW-1:0];
    assign cur_s      = in_range_s ? mmio_r[reg_idx_s] : 32'd0;
    assign merged_s   = byte_merge(cur_s, req_wdata[win_s], req_byteen[win_s]);

    // Next-state and combinational ready for the granted master
    always_comb begin
        state_nx_s  = state_r;
        grant_vec_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nx_s  = ST_RESP;
                    grant_vec_s = NUM_REQ'(1'b1) << win_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RESP: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state and one-cycle response strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            rsp_valid_r <= '0;
        end else begin
            state_r     <= state_nx_s;
            rsp_valid_r <= grant_s ? grant_vec_s : {NUM_REQ{1'b0}};
        end
    end

    // Rotation pointer and lock bookkeeping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr_r     <= '0;
            lock_valid_r <= 1'b0;
            lock_owner_r <= '0;
            lock_count_r <= '0;
        end else if (grant_s) begin
            if (keep_lock_s) begin
                lock_valid_r <= 1'b1;
                lock_owner_r <= win_s;
                lock_count_r <= cnt_eff_s + CW'(1);
            end else begin
                lock_valid_r <= 1'b0;
                lock_count_r <= '0;
                rr_ptr_r     <= wrap_inc(win_s);
            end
        end else if ((state_r == ST_IDLE) && lock_valid_r && !req_valid[lock_owner_r]) begin
            lock_valid_r <= 1'b0;
            lock_count_r <= '0;
        end
    end

    // Register bank writes and read-data capture at the accept edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mmio_r      <= '0;
            rsp_rdata_r <= 32'd0;
        end else if (grant_s) begin
            if (req_write[win_s]) begin
                if (in_range_s) begin
                    mmio_r[reg_idx_s] <= merged_s;
                end
                rsp_rdata_r <= in_range_s ? merged_s : 32'd0;
            end else begin
                rsp_rdata_r <= in_range_s ? mmio_inputs[reg_idx_s] : 32'd0;
            end
        end
    end

    assign req_ready    = grant_vec_s;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign mmio_outputs = mmio_r;

endmodule
